// File: rtl/mem_hs_ctrl.sv
// rtl/mem_hs_ctrl.sv - handshaked single-port memory with byte enables, held read response and hardware init
module mem_hs_ctrl #(
    parameter int                   DinLength  = 32,
    parameter int                   AddrWidth  = 3,
    parameter logic [DinLength-1:0] INIT_VALUE = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Valid,
    output logic                   Ready,
    input  logic                   R_W,
    input  logic [AddrWidth-1:0]   Addr,
    input  logic [DinLength-1:0]   Din,
    input  logic [DinLength/8-1:0] Be,
    output logic [DinLength-1:0]   Dout,
    output logic                   Dout_Valid,
    input  logic                   Dout_Ready,
    output logic                   Init_Done
);

    localparam int                   Depth     = 2 ** AddrWidth;
    localparam int                   NumBytes  = DinLength / 8;
    localparam logic [AddrWidth-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   init_cnt_q, init_cnt_d;
    logic [DinLength-1:0]   dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   init_done_q, init_done_d;

    logic [DinLength-1:0]   mem_q [Depth];
    logic                   mem_we;
    logic [AddrWidth-1:0]   mem_waddr;
    logic [DinLength-1:0]   mem_wdata;
    logic [DinLength-1:0]   merged_word;

    // Read-modify-write word: current contents with enabled bytes replaced by Din
    always_comb begin
        merged_word = mem_q[Addr];
        for (int i = 0; i < NumBytes; i++) begin
            if (Be[i]) begin
                merged_word[8*i +: 8] = Din[8*i +: 8];
            end
        end
    end

    // Next-state, response and memory-write decode for the INIT/IDLE/RESP controller
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        init_done_d  = init_done_q;
        mem_we       = 1'b0;
        mem_waddr    = Addr;
        mem_wdata    = merged_word;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = INIT_VALUE;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (Valid) begin
                    if (R_W) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d       = mem_q[Addr];
                        dout_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (Dout_Ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Controller registers; reset restarts initialisation and drops any pending response
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    // Storage array; contents survive reset and are cleared by the INIT walk instead
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Ready      = (state_q == ST_IDLE);
    assign Dout       = dout_q;
    assign Dout_Valid = dout_valid_q;
    assign Init_Done  = init_done_q;

endmodule

// File: doc/mem_hs_ctrl.md
# mem_hs_ctrl

Parametrised single-port synchronous memory with valid/ready request handshake, per-byte write enables, a held read response with its own valid/ready handshake, and a hardware initialisation sequence after reset. It is the next-generation data store for the datapath, replacing the fixed, unhandshaked memory. Every location holds a defined value after reset instead of X. Upstream masters issue read/write requests; downstream consumers drain read data at their own pace.

## Interface
- DinLength, 32, data word width in bits; must be a multiple of 8.
- AddrWidth, 3, address width; Depth = 2**AddrWidth words.
- INIT_VALUE, 0, word written to every location during initialisation.

- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- Valid  in  1  request valid.
- Ready  out  1  request accepted when Valid && Ready at posedge.
- R_W  in  1  1 = write, 0 = read; sampled with the request.
- Addr  in  AddrWidth  word address.
- Din  in  DinLength  write data.
- Be  in  DinLength/8  byte enables; bit i controls Din[8i+7:8i]; ignored for reads.
- Dout  out  DinLength  read data; stable while Dout_Valid is high.
- Dout_Valid  out  1  read response valid.
- Dout_Ready  in  1  consumer accepts response when Dout_Valid && Dout_Ready at posedge.
- Init_Done  out  1  high once initialisation completes; low during INIT.

## Operation
- FSM states: INIT, IDLE, RESP. All outputs are registered except Ready, which is decoded from the state: Ready = (state == IDLE).
- Reset (sampled high at posedge):
  - state <= INIT, init counter <= 0.
  - Dout <= 0, Dout_Valid <= 0, Init_Done <= 0.
  - Any pending response is discarded.
  - Memory contents are not cleared by Reset itself; the INIT sequence clears them.
- INIT:
  - Each posedge with Reset low writes INIT_VALUE to Mem[counter], then counter increments.
  - On the edge that writes Depth-1: state <= IDLE, Init_Done <= 1.
  - Requests are ignored because Ready = 0.
- IDLE, accepted write (Valid && R_W):
  - For each i with Be[i] = 1, Mem[Addr] byte i <= Din byte i. Other bytes are unchanged.
  - Be = 0 is a legal no-op write.
  - State stays IDLE, so back-to-back writes run at one per cycle.
- IDLE, accepted read (Valid && !R_W):
  - Dout <= Mem[Addr], Dout_Valid <= 1, state <= RESP.
- RESP:
  - Ready = 0. Dout and Dout_Valid hold.
  - When Dout_Ready is high: Dout_Valid <= 0, state <= IDLE. Dout keeps its last value.
- Valid low in IDLE: no state change.
- R_W, Addr, Din and Be are don't-care when the request is not accepted.

## Timing
- Reset release: for the first posedge with Reset low (edge 1), edge n writes address n-1. Edge Depth sets Init_Done = 1 and Ready = 1. The first request can be accepted at edge Depth+1.
- Write latency: data is visible to a read accepted on the next edge.
- Read latency: Dout_Valid is high in the cycle after acceptance. With Dout_Ready held high:
  - The response is consumed at the following edge.
  - Ready is high again one cycle later.
  - Peak read throughput is one read per 2 cycles.
- A write accepted at edge k followed by a read of the same address accepted at edge k+1 returns the new data; there is no bypass path.
- Reset asserted in any state, including mid-INIT or RESP, takes effect at that edge and restarts INIT from address 0.
- Dout_Ready is ignored while Dout_Valid = 0.

## Test plan
- Reset for 2 cycles, then release (Depth = 8) -> Ready and Init_Done rise after exactly 8 edges; reading addresses 0..7 returns 0x00000000 each.
- Write 0xDEADBEEF to address 3 with Be = 4'b1111, then write 0x11223344 to address 3 with Be = 4'b0101 -> a read of address 3 returns 0xDE22BE44.
- Read address 3 with Dout_Ready held low for 5 cycles -> Dout_Valid stays 1, Dout stays 0xDE22BE44, Ready stays 0; raise Dout_Ready -> Dout_Valid falls at the next edge and Ready rises.
- Back-to-back writes to addresses 0..7 (data = address × 0x01010101, Valid held high) -> one write per cycle with no stalls; readback matches.
- Reset asserted while in RESP and again at INIT address 4 -> Dout_Valid is 0 and Dout is 0 the next cycle; INIT restarts and completes 8 edges after release.
- Valid high during INIT with R_W = 1 -> no write occurs; the targeted location reads INIT_VALUE afterwards.
